cacheline_adaptor: RTL

- Sits between the cache's 256-bit line port (upstream) and the physical-memory model's 64-bit burst port (downstream).
- Converts one line read into a 4-beat burst fill, and one line write into a 4-beat burst writeback.
- Returns a single-cycle response to the cache when each transfer completes.

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cacheline_adaptor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cla_pkg.sv
// Shared types, default geometry and address helper for the cacheline adaptor.
// Optional protocol checker in the top is enabled by CLA_PROTOCOL_CHECK_EN.
package cla_pkg;

  localparam int CLA_LINE_W  = 256;
  localparam int CLA_BURST_W = 64;
  localparam int CLA_ADDR_W  = 32;

  localparam int BEATS     = CLA_LINE_W / CLA_BURST_W;
  localparam int CNT_W     = $clog2(BEATS);
  localparam int CLA_OFF_W = $clog2(CLA_LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } cla_state_t;

  // Clear the byte-offset bits so the address points at the start of a line.
  function automatic logic [CLA_ADDR_W-1:0] line_align(input logic [CLA_ADDR_W-1:0] addr);
    return {addr[CLA_ADDR_W-1:CLA_OFF_W], {CLA_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory port (4-beat fill/writeback).
// Define CLA_PROTOCOL_CHECK_EN to enable the sticky err_o protocol checker.
module cacheline_adaptor
  import cla_pkg::*;
#(
  parameter int LINE_W  = CLA_LINE_W,
  parameter int BURST_W = CLA_BURST_W,
  parameter int ADDR_W  = CLA_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i,
  output logic               err_o
);

  localparam bit  DEFAULT_GEOM = (LINE_W == CLA_LINE_W) && (BURST_W == CLA_BURST_W);
  localparam int  N_BEATS  = DEFAULT_GEOM ? BEATS : (LINE_W / BURST_W);
  localparam int  CNT_BITS = DEFAULT_GEOM ? CNT_W :
                             ((N_BEATS > 1) ? $clog2(N_BEATS) : 1);
  localparam int  OFF_BITS = $clog2(LINE_W / 8);
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(N_BEATS - 1);

  cla_state_t          state_reg, state_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [LINE_W-1:0]   buffer_reg, buffer_next;
  logic [LINE_W-1:0]   line_reg;
  logic [ADDR_W-1:0]   aligned_addr;
  logic [BURST_W-1:0]  beat_slices [N_BEATS];
  logic                load_line;
  logic                fill_beat;
  logic                line_load;
  logic                unused_addr_bits;

  generate
    if ((ADDR_W == CLA_ADDR_W) && (LINE_W == CLA_LINE_W)) begin : g_align_pkg
      assign aligned_addr = line_align(address_i);
    end else begin : g_align_local
      assign aligned_addr = {address_i[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
    end
  endgenerate

  // Offset bits never reach memory; the adaptor only moves whole lines.
  assign unused_addr_bits = ^address_i[OFF_BITS-1:0];

  assign load_line = (state_reg == IDLE) && write_i;
  assign fill_beat = (state_reg == RD) && resp_i;

  // Each beat lane is loaded whole from the cache or, one at a time, from memory.
  genvar gi;
  generate
    for (gi = 0; gi < N_BEATS; gi++) begin : g_beat
      assign beat_slices[gi] = buffer_reg[gi*BURST_W +: BURST_W];
      assign buffer_next[gi*BURST_W +: BURST_W] =
          load_line ? line_i[gi*BURST_W +: BURST_W] :
          (fill_beat && (cnt_reg == CNT_BITS'(gi))) ? burst_i :
          beat_slices[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    unique case (state_reg)
      IDLE: begin
        if (write_i) begin
          addr_next  = aligned_addr;
          cnt_next   = '0;
          state_next = WR;
        end else if (read_i) begin
          addr_next  = aligned_addr;
          cnt_next   = '0;
          state_next = RD;
        end
      end
      RD, WR: begin
        if (resp_i) begin
          if (cnt_reg == LAST_BEAT) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only a completed fill updates what the cache sees on line_o.
  assign line_load = (state_reg == RD) && (state_next == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      buffer_reg <= '0;
      line_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      buffer_reg <= buffer_next;
      if (line_load) begin
        line_reg <= buffer_next;
      end
    end
  end

  assign line_o    = line_reg;
  assign address_o = addr_reg;
  assign read_o    = (state_reg == RD);
  assign write_o   = (state_reg == WR);
  assign resp_o    = (state_reg == DONE);
  assign burst_o   = (state_reg == WR) ? beat_slices[cnt_reg] : '0;

`ifdef CLA_PROTOCOL_CHECK_EN
  logic err_reg;
  logic proto_violation;

  assign proto_violation = (((state_reg == IDLE) || (state_reg == DONE)) && resp_i) ||
                           ((state_reg == IDLE) && read_i && write_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (proto_violation) begin
      err_reg <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && proto_violation) begin
      $error("cacheline_adaptor: protocol violation at %0t in state %s", $time, state_reg.name());
    end
  end
`endif

  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

endmodule
